alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/alu_arbiter_alu.sv | 23 ++
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU opcodes and arbiter FSM states.
package alu_arbiter_pkg;

  localparam int ALU_DATA_W = 64;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_BEQ = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit ALU shared by both requesters; unsupported opcodes produce zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  input  logic [ALU_DATA_W-1:0] a_i,
  input  logic [ALU_DATA_W-1:0] b_i,
  output logic [ALU_DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_BEQ: result_o = {{(ALU_DATA_W-1){1'b0}}, (a_i == b_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one non-pipelined ALU between two requesters,
// with latched operands and a registered result returned on per-requester response channels.
//
// state | meaning
// IDLE  | waiting for a request; grant the round-robin winner and latch its operands
// EXEC  | ALU evaluates latched operands; result captured at the end of the cycle
// RESP  | result presented to the owner; held until the owner takes it
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic              busy
);

  if (DATA_W != ALU_DATA_W || CTRL_W != ALU_CTRL_W) begin : g_bad_width
    $error("alu_arbiter: the shared ALU is fixed at 64-bit data and 4-bit control");
  end

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   alu_res;
  logic                any_valid;
  logic                grant;

  alu_arbiter_alu u_alu (
    .ctrl_i   (ctrl_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res)
  );

  // On a tie the requester that was not served last wins; otherwise the lone requester.
  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid & req1_valid) ? ~last_grant_q : ~req0_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req0_ready = ~rst & ~grant;
          req1_ready = ~rst & grant;
          owner_d    = grant;
          ctrl_d     = grant ? req1_ctrl : req0_ctrl;
          a_d        = grant ? req1_a : req0_a;
          b_d        = grant ? req1_b : req0_b;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_res;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        if (owner_q ? resp1_ready : resp0_ready) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
    end
  end

  assign resp0_data = res_q;
  assign resp1_data = res_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model compared every cycle,
// directed literal scenarios, then randomized traffic with backpressure and occasional resets.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [63:0] resp0_data, resp1_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_arbiter #(.DATA_W(64), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    case (c)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b1010: return (a == b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction view: one operation outstanding, its age in cycles since acceptance,
  // who owns it, who was last served, and the value the result register shows.
  bit          m_pend;
  int          m_age;
  bit          m_owner;
  bit          m_last;
  logic [63:0] m_pres;
  logic [63:0] m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_age  <= 0;
      m_last <= 1'b1;
      m_res  <= 64'd0;
    end else if (!m_pend) begin
      if (req0_valid || req1_valid) begin
        m_pend  <= 1'b1;
        m_age   <= 0;
        if (req0_valid && req1_valid) begin
          m_owner <= !m_last;
          m_pres  <= m_last ? ref_alu(req0_ctrl, req0_a, req0_b) : ref_alu(req1_ctrl, req1_a, req1_b);
        end else if (req0_valid) begin
          m_owner <= 1'b0;
          m_pres  <= ref_alu(req0_ctrl, req0_a, req0_b);
        end else begin
          m_owner <= 1'b1;
          m_pres  <= ref_alu(req1_ctrl, req1_a, req1_b);
        end
      end
    end else if (m_age == 0) begin
      m_age <= 1;
      m_res <= m_pres;
    end else if (m_owner ? resp1_ready : resp0_ready) begin
      m_pend <= 1'b0;
      m_last <= m_owner;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_req0_ready", {63'd0, req0_ready},
            {63'd0, !rst && !m_pend && req0_valid && (!req1_valid || m_last)});
      check("m_req1_ready", {63'd0, req1_ready},
            {63'd0, !rst && !m_pend && req1_valid && (!req0_valid || !m_last)});
      check("m_resp0_valid", {63'd0, resp0_valid}, {63'd0, m_pend && m_age == 1 && !m_owner});
      check("m_resp1_valid", {63'd0, resp1_valid}, {63'd0, m_pend && m_age == 1 && m_owner});
      check("m_busy", {63'd0, busy}, {63'd0, m_pend});
      check("m_resp0_data", resp0_data, m_res);
      check("m_resp1_data", resp1_data, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit n, input bit v, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    if (n) begin
      req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
    end
  endtask

  // Single uncontended op with resp_ready high: accept, EXEC, RESP, back to IDLE.
  task automatic run_op(input bit n, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input string nm);
    drive(n, 1'b1, c, a, b);
    @(negedge clk);
    check({nm, "_ready"}, {63'd0, n ? req1_ready : req0_ready}, 64'd1);
    step();
    drive(n, 1'b0, c, a, b);
    @(negedge clk);
    check({nm, "_exec_valid"}, {63'd0, n ? resp1_valid : resp0_valid}, 64'd0);
    @(negedge clk);
    check({nm, "_resp_valid"}, {63'd0, n ? resp1_valid : resp0_valid}, 64'd1);
    check({nm, "_other_valid"}, {63'd0, n ? resp0_valid : resp1_valid}, 64'd0);
    check({nm, "_data"}, n ? resp1_data : resp0_data, exp);
    step();
  endtask

  task automatic rand_req(input bit n);
    logic [3:0]  c;
    logic [63:0] a, b;
    case ($urandom_range(0, 5))
      0: c = 4'b0000;
      1: c = 4'b0001;
      2: c = 4'b0100;
      3: c = 4'b0101;
      4: c = 4'b1010;
      default: c = 4'($urandom);
    endcase
    a = {$urandom, $urandom};
    b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) begin
      a = 64'($urandom_range(0, 15));
      b = 64'($urandom_range(0, 15));
    end
    drive(n, 1'b1, c, a, b);
  endtask

  initial begin
    bit acc0, acc1;
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'b0000, 64'd1, 64'd2);
    drive(1'b1, 1'b1, 4'b0001, 64'd3, 64'd4);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;

    // reset held with both valids high
    step();
    chk_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
      check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
      check("rst_resp0_valid", {63'd0, resp0_valid}, 64'd0);
      check("rst_resp1_valid", {63'd0, resp1_valid}, 64'd0);
      check("rst_data", resp0_data, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
    end
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 4'b0000, 64'd0, 64'd0);

    run_op(1'b0, 4'b0000, 64'd5, 64'd7, 64'd12, "add");
    run_op(1'b1, 4'b0001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, "sub");
    run_op(1'b1, 4'b1010, 64'hDEAD, 64'hDEAD, 64'd1, "beq");
    run_op(1'b1, 4'b1111, 64'd9, 64'd9, 64'd0, "badop");

    // tie after reset: req0 first, then a fresh req0 loses the next tie to req1
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 1'b1, 4'b0100, 64'hF0, 64'h3C);
    drive(1'b1, 1'b1, 4'b0101, 64'hF0, 64'h3C);
    @(negedge clk);
    check("tie1_req0_ready", {63'd0, req0_ready}, 64'd1);
    check("tie1_req1_ready", {63'd0, req1_ready}, 64'd0);
    step();
    drive(1'b0, 1'b1, 4'b0000, 64'd1, 64'd1);
    @(negedge clk);
    check("tie1_exec_ready", {63'd0, req0_ready | req1_ready}, 64'd0);
    @(negedge clk);
    check("tie1_resp0_valid", {63'd0, resp0_valid}, 64'd1);
    check("tie1_data", resp0_data, 64'h30);
    step();
    @(negedge clk);
    check("tie2_req1_ready", {63'd0, req1_ready}, 64'd1);
    check("tie2_req0_ready", {63'd0, req0_ready}, 64'd0);
    step();
    drive(1'b1, 1'b0, 4'b0000, 64'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("tie2_resp1_valid", {63'd0, resp1_valid}, 64'd1);
    check("tie2_data", resp1_data, 64'hFC);
    step();
    @(negedge clk);
    check("tie3_req0_ready", {63'd0, req0_ready}, 64'd1);
    step();
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("tie3_data", resp0_data, 64'd2);
    step();

    // response backpressure
    resp0_ready = 1'b0;
    drive(1'b0, 1'b1, 4'b0000, 64'd10, 64'd20);
    step();
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    step();
    drive(1'b0, 1'b1, 4'b0001, 64'd8, 64'd1);
    drive(1'b1, 1'b1, 4'b0100, 64'd8, 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_resp0_valid", {63'd0, resp0_valid}, 64'd1);
      check("bp_data", resp0_data, 64'd30);
      check("bp_req0_ready", {63'd0, req0_ready}, 64'd0);
      check("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
      check("bp_busy", {63'd0, busy}, 64'd1);
    end
    step();
    resp0_ready = 1'b1;
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 4'b0000, 64'd0, 64'd0);
    step();
    @(negedge clk);
    check("bp_release_busy", {63'd0, busy}, 64'd0);
    step();

    // reset while in EXEC
    drive(1'b0, 1'b1, 4'b0000, 64'd1, 64'd2);
    step();
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rstx_busy", {63'd0, busy}, 64'd0);
      check("rstx_resp_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
      check("rstx_data", resp0_data, 64'd0);
    end

    // reset while in RESP, owner not ready
    step();
    resp0_ready = 1'b0;
    drive(1'b0, 1'b1, 4'b0000, 64'd4, 64'd4);
    step();
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rstr_pre_valid", {63'd0, resp0_valid}, 64'd1);
    check("rstr_pre_data", resp0_data, 64'd8);
    step();
    rst = 1'b0;
    resp0_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstr_busy", {63'd0, busy}, 64'd0);
      check("rstr_resp_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
      check("rstr_data", resp0_data, 64'd0);
    end
    step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      step();
      if (acc0 || (req0_valid && $urandom_range(0, 19) == 0)) req0_valid = 1'b0;
      if (acc1 || (req1_valid && $urandom_range(0, 19) == 0)) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0) rand_req(1'b0);
      if (!req1_valid && $urandom_range(0, 2) == 0) rand_req(1'b1);
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
